// File: rtl/conv_ctrl_pkg.sv
// rtl/conv_ctrl_pkg.sv - shared types and helpers for shared-engine arbiters
package conv_ctrl_pkg;

  localparam int TIMER_W = 8;
  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef enum logic {OK, TIMEOUT} outcome_t;

  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned id);
    return MAX_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/conv_engine_arbiter_if.sv
// rtl/conv_engine_arbiter_if.sv - requester and engine handshake bundle
interface conv_engine_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] err;
  logic [ID_W-1:0]    sel;
  logic               eng_valid_in;
  logic               eng_valid_out;
  logic               busy;
  logic               stray_err;

  modport master (
    output req, eng_valid_out,
    input  gnt, done, err, sel, eng_valid_in, busy, stray_err
  );

  modport slave (
    input  req, eng_valid_out,
    output gnt, done, err, sel, eng_valid_in, busy, stray_err
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search starting after last
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] winner
);
  localparam int ID_W = $clog2(NUM_REQ);

  // Scan farthest-to-nearest so the nearest set bit after last is written last.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(last) + i) % NUM_REQ]) begin
        any    = 1'b1;
        winner = ID_W'((int'(last) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/conv_engine_arbiter.sv
// rtl/conv_engine_arbiter.sv - round-robin owner of one shared Conv2D engine
module conv_engine_arbiter
  import conv_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ENGINE_LATENCY = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv_engine_arbiter_if.slave   bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES > 255 || ENGINE_LATENCY < 1) begin : g_param_check
    $error("conv_engine_arbiter: parameter out of range");
  end

  state_t               state, state_nxt;
  outcome_t             outcome;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [ID_W-1:0]      last, last_nxt;
  logic [ID_W-1:0]      sel_r, sel_nxt;
  logic [NUM_REQ-1:0]   gnt_r, gnt_nxt;
  logic [NUM_REQ-1:0]   done_r, done_nxt;
  logic [NUM_REQ-1:0]   err_r, err_nxt;
  logic                 valid_in_r, valid_in_nxt;
  logic                 busy_r, busy_nxt;
  logic                 stray_r, stray_nxt;
  logic                 any;
  logic [ID_W-1:0]      winner;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req),
    .last   (last),
    .any    (any),
    .winner (winner)
  );

  always_comb begin
    state_nxt    = state;
    outcome      = OK;
    timer_nxt    = timer;
    last_nxt     = last;
    sel_nxt      = sel_r;
    gnt_nxt      = gnt_r;
    done_nxt     = '0;
    err_nxt      = '0;
    valid_in_nxt = 1'b0;
    stray_nxt    = stray_r | (bus.eng_valid_out && state != WAIT);
    case (state)
      IDLE: begin
        if (any) begin
          state_nxt    = ISSUE;
          sel_nxt      = winner;
          gnt_nxt      = NUM_REQ'(onehot(32'(winner)));
          valid_in_nxt = 1'b1;
        end
      end
      ISSUE: begin
        timer_nxt = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A completion arriving on the last allowed cycle beats the watchdog.
        if (bus.eng_valid_out) begin
          outcome   = OK;
          state_nxt = DONE;
        end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          outcome   = TIMEOUT;
          state_nxt = DONE;
        end else if (timer != '1) begin
          timer_nxt = timer + 1'b1;
        end
        if (state_nxt == DONE) begin
          if (outcome == OK) done_nxt = gnt_r;
          else               err_nxt  = gnt_r;
        end
      end
      DONE: begin
        last_nxt  = sel_r;
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      last       <= ID_W'(NUM_REQ - 1);
      sel_r      <= '0;
      gnt_r      <= '0;
      done_r     <= '0;
      err_r      <= '0;
      valid_in_r <= 1'b0;
      busy_r     <= 1'b0;
      stray_r    <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      last       <= last_nxt;
      sel_r      <= sel_nxt;
      gnt_r      <= gnt_nxt;
      done_r     <= done_nxt;
      err_r      <= err_nxt;
      valid_in_r <= valid_in_nxt;
      busy_r     <= busy_nxt;
      stray_r    <= stray_nxt;
    end
  end

  assign bus.gnt          = gnt_r;
  assign bus.done         = done_r;
  assign bus.err          = err_r;
  assign bus.sel          = sel_r;
  assign bus.eng_valid_in = valid_in_r;
  assign bus.busy         = busy_r;
  assign bus.stray_err    = stray_r;

endmodule
